// File: rtl/rs_enc_lfsr_pkg.sv
// rs_enc_lfsr_pkg
//   Shared Reed-Solomon code parameters, symbol/counter types, the encoder
//   state enum and the GF(2^m) helper functions. rs_gen_poly() builds the
//   generator polynomial g(x) = prod (x - alpha^(genstart+i)) at elaboration
//   time, so the encoder stores no coefficients at run time.
package rs_enc_lfsr_pkg;

    localparam int RS_N         = 240;
    localparam int RS_CHECK     = 30;
    localparam int RS_M         = 8;
    localparam int RS_GENSTART  = 0;
    localparam int RS_FRAME_MAX = RS_N - RS_CHECK;
    localparam logic [RS_M:0] RS_IRRPOL = 9'd285;

    // Bits needed to hold values 0..value-1.
    function automatic int clogb2(input int value);
        int v;
        int w;
        v = value - 32'sd1;
        w = 32'sd0;
        while (v > 32'sd0) begin
            w = w + 32'sd1;
            v = v >>> 1;
        end
        return w;
    endfunction

    localparam int RS_PTR_W = clogb2(RS_N);
    localparam int RS_CNT_W = clogb2(RS_CHECK);

    typedef logic [RS_M-1:0]     data_t;
    typedef logic [RS_PTR_W-1:0] ptr_t;
    typedef logic [RS_CNT_W-1:0] cnt_t;

    typedef enum logic [0:0] {
        cDATA_STATE   = 1'b0,
        cPARITY_STATE = 1'b1
    } state_t;

    localparam data_t RS_ALPHA = 8'd2;

    // GF(2^m) multiply, shift-and-add reduced by the field polynomial.
    // With a constant operand this collapses to a small XOR network.
    function automatic data_t gf_mult_a_by_b(input data_t a, input data_t b);
        data_t acc;
        data_t sh;
        acc = {RS_M{1'b0}};
        sh  = a;
        for (int i = 0; i < RS_M; i++) begin
            if (b[i]) acc = acc ^ sh;
            if (sh[RS_M-1]) sh = {sh[RS_M-2:0], 1'b0} ^ RS_IRRPOL[RS_M-1:0];
            else            sh = {sh[RS_M-2:0], 1'b0};
        end
        return acc;
    endfunction

    // alpha^e for e >= 0.
    function automatic data_t gf_alpha_pow(input int e);
        data_t p;
        p = 8'd1;
        for (int i = 0; i < (e % ((32'sd1 <<< RS_M) - 32'sd1)); i++) begin
            p = gf_mult_a_by_b(p, RS_ALPHA);
        end
        return p;
    endfunction

    // Coefficient idx (of x^idx) of the monic generator polynomial.
    // The leading coefficient g[check] = 1 is implicit in the LFSR.
    function automatic data_t rs_gen_poly(input int check, input int genstart, input int idx);
        data_t g [0:RS_CHECK];
        data_t root;
        for (int j = 0; j <= RS_CHECK; j++) g[j] = {RS_M{1'b0}};
        g[0] = 8'd1;
        root = gf_alpha_pow(genstart);
        for (int k = 0; k < check; k++) begin
            // g(x) <- g(x) * (x + root); minus equals plus in GF(2^m)
            for (int j = check; j > 0; j--) begin
                g[j] = g[j-1] ^ gf_mult_a_by_b(g[j], root);
            end
            g[0] = gf_mult_a_by_b(g[0], root);
            root = gf_mult_a_by_b(root, RS_ALPHA);
        end
        return g[idx];
    endfunction

endpackage

// File: rtl/rs_enc_lfsr_cell.sv
// rs_enc_lfsr_cell
//   One stage of the RS division LFSR: stage <= prev ^ (fb * COEF).
//   Ports:
//     iclk, ireset, iclkena - clock, sync active-high reset, clock enable
//     ien                   - stage update (data accept or parity shift)
//     ifb                   - feedback symbol (0 while shifting out parity)
//     iprev                 - previous stage value (0 for stage 0 / restart)
//     ostage                - registered stage value
module rs_enc_lfsr_cell
    import rs_enc_lfsr_pkg::*;
#(
    parameter data_t COEF = 8'd0
) (
    input  logic  iclk,
    input  logic  ireset,
    input  logic  iclkena,
    input  logic  ien,
    input  data_t ifb,
    input  data_t iprev,
    output data_t ostage
);

    data_t stage_r;

    // Stage register: multiply-accumulate on update, cleared by reset.
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (ireset) begin
                stage_r <= {RS_M{1'b0}};
            end else if (ien) begin
                stage_r <= iprev ^ gf_mult_a_by_b(ifb, COEF);
            end
        end
    end

    assign ostage = stage_r;

endmodule

// File: rtl/rs_enc_lfsr.sv
// rs_enc_lfsr
//   Systematic Reed-Solomon encoder (n=240, check=30, GF(2^8)). Data symbols
//   pass through with one enabled cycle of latency, then the check parity
//   symbols held in the division LFSR are shifted out.
//   Ports:
//     iclk, ireset, iclkena  - clock, sync active-high reset, clock enable
//     isop, ival, ieop, idat - input frame stream
//     ordy                   - encoder accepts data (data phase)
//     osop, oval, oeop, odat - output codeword stream (registered)
//     oflag                  - 1 while odat carries a parity symbol
module rs_enc_lfsr
    import rs_enc_lfsr_pkg::*;
(
    input  logic            iclk,
    input  logic            ireset,
    input  logic            iclkena,
    input  logic            isop,
    input  logic            ival,
    input  logic            ieop,
    input  logic [RS_M-1:0] idat,
    output logic            ordy,
    output logic            osop,
    output logic            oval,
    output logic            oeop,
    output logic [RS_M-1:0] odat,
    output logic            oflag
);

    state_t state_r;
    state_t state_next_s;
    cnt_t   pcnt_r;
    ptr_t   dcnt_r;
    ptr_t   dcnt_next_s;
    data_t  fb_s;
    data_t  lfsr_s [0:RS_CHECK-1];
    data_t  prev_s [0:RS_CHECK-1];
    logic   ordy_s;
    logic   accept_s;
    logic   shift_s;
    logic   last_s;
    logic   stage_en_s;

    logic   osop_r;
    logic   oval_r;
    logic   oeop_r;
    logic   oflag_r;
    data_t  odat_r;

    assign ordy_s     = (state_r == cDATA_STATE);
    assign accept_s   = iclkena & ival & ordy_s;
    assign shift_s    = iclkena & (state_r == cPARITY_STATE);
    assign stage_en_s = accept_s | shift_s;

    // Symbols since isop; isop restarts the count at this symbol.
    assign dcnt_next_s = isop ? ptr_t'(32'd1) : (dcnt_r + ptr_t'(32'd1));
    // Frame ends on ieop or on the last symbol that still fits the code.
    assign last_s      = ieop | (dcnt_next_s == ptr_t'(RS_FRAME_MAX));

    // LFSR feedback; isop behaves as if the register were already cleared.
    always_comb begin
        fb_s = {RS_M{1'b0}};
        if (accept_s) begin
            if (isop) fb_s = idat;
            else      fb_s = idat ^ lfsr_s[RS_CHECK-1];
        end else begin
            fb_s = {RS_M{1'b0}};
        end
    end

    // Stage chaining; zeroed on restart so a partial frame is abandoned.
    always_comb begin
        prev_s[0] = {RS_M{1'b0}};
        for (int i = 1; i < RS_CHECK; i++) begin
            if (accept_s && isop) prev_s[i] = {RS_M{1'b0}};
            else                  prev_s[i] = lfsr_s[i-1];
        end
    end

    for (genvar gi = 0; gi < RS_CHECK; gi++) begin : g_stage
        localparam data_t COEF = rs_gen_poly(RS_CHECK, RS_GENSTART, gi);
        rs_enc_lfsr_cell #(
            .COEF(COEF)
        ) u_cell (
            .iclk    (iclk),
            .ireset  (ireset),
            .iclkena (iclkena),
            .ien     (stage_en_s),
            .ifb     (fb_s),
            .iprev   (prev_s[gi]),
            .ostage  (lfsr_s[gi])
        );
    end

    // Next-state decode for the data/parity FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            cDATA_STATE: begin
                if (accept_s && last_s) state_next_s = cPARITY_STATE;
                else                    state_next_s = cDATA_STATE;
            end
            cPARITY_STATE: begin
                if (shift_s && (pcnt_r == cnt_t'(32'd0))) state_next_s = cDATA_STATE;
                else                                      state_next_s = cPARITY_STATE;
            end
            default: state_next_s = cDATA_STATE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (ireset) begin
                state_r <= cDATA_STATE;
                pcnt_r  <= cnt_t'(32'd0);
                dcnt_r  <= ptr_t'(32'd0);
                osop_r  <= 1'b0;
                oval_r  <= 1'b0;
                oeop_r  <= 1'b0;
                oflag_r <= 1'b0;
                odat_r  <= {RS_M{1'b0}};
            end else begin
                state_r <= state_next_s;
                if (accept_s) begin
                    dcnt_r  <= last_s ? ptr_t'(32'd0) : dcnt_next_s;
                    pcnt_r  <= cnt_t'(RS_CHECK - 1);
                    odat_r  <= idat;
                    oval_r  <= 1'b1;
                    oflag_r <= 1'b0;
                    osop_r  <= isop;
                    oeop_r  <= 1'b0;
                end else if (shift_s) begin
                    if (pcnt_r != cnt_t'(32'd0)) pcnt_r <= pcnt_r - cnt_t'(32'd1);
                    odat_r  <= lfsr_s[RS_CHECK-1];
                    oval_r  <= 1'b1;
                    oflag_r <= 1'b1;
                    osop_r  <= 1'b0;
                    oeop_r  <= (pcnt_r == cnt_t'(32'd0));
                end else begin
                    oval_r  <= 1'b0;
                    oflag_r <= 1'b0;
                    osop_r  <= 1'b0;
                    oeop_r  <= 1'b0;
                end
            end
        end
    end

    assign ordy  = ordy_s;
    assign osop  = osop_r;
    assign oval  = oval_r;
    assign oeop  = oeop_r;
    assign oflag = oflag_r;
    assign odat  = odat_r;

endmodule

// File: tb/tb_rs_enc_lfsr.sv
module tb_rs_enc_lfsr;

    typedef struct packed {
        logic       val;
        logic       sop;
        logic       eop;
        logic       flag;
        logic [7:0] dat;
    } smp_t;

    logic       iclk = 1'b0;
    logic       ireset, iclkena, isop, ival, ieop;
    logic [7:0] idat;
    logic       ordy, osop, oval, oeop, oflag;
    logic [7:0] odat;

    int   errors = 0;
    int   checks = 0;
    int   exp_t [0:254];
    int   log_t [0:255];
    int   gb    [0:30];
    smp_t mq[$];
    smp_t vq[$];
    smp_t refa[$];
    int   sent[$];
    int   frame_a[$];
    bit   mon_en  = 1'b0;
    bit   rnd_ena = 1'b0;
    int   rdy_low = 0;

    rs_enc_lfsr dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .isop(isop), .ival(ival), .ieop(ieop), .idat(idat),
        .ordy(ordy), .osop(osop), .oval(oval), .oeop(oeop),
        .odat(odat), .oflag(oflag)
    );

    always #5 iclk = ~iclk;

    // Output monitor: one sample per enabled edge, taken 1 time unit later.
    always @(posedge iclk) begin : monitor
        logic en_s;
        en_s = iclkena;
        #1;
        if (mon_en && en_s) mq.push_back({oval, osop, oeop, oflag, odat});
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    task automatic set_ena();
        iclkena = rnd_ena ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iclk);
            ival = 1'b0; isop = 1'b0; ieop = 1'b0;
            set_ena();
            @(posedge iclk);
        end
    endtask

    task automatic put(input logic sop, input logic eop, input logic [7:0] d);
        bit go;
        int g;
        go = 1'b0;
        g  = 0;
        while (!go && g < 2000) begin
            @(negedge iclk);
            isop = sop; ieop = eop; idat = d; ival = 1'b1;
            set_ena();
            if (iclkena && !ordy) rdy_low++;
            go = iclkena && ordy;
            @(posedge iclk);
            g++;
        end
        if (!go) chk("put_accept", 32'(go), 32'd1);
        sent.push_back(int'(d));
    endtask

    task automatic send_rand(input int len, input bit with_eop);
        for (int k = 0; k < len; k++) begin
            put(k == 0, with_eop && (k == len - 1), 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic collect();
        vq.delete();
        foreach (mq[i]) if (mq[i].val) vq.push_back(mq[i]);
    endtask

    task automatic clear_logs();
        #2;
        mq.delete(); vq.delete(); sent.delete();
    endtask

    task automatic wait_out(input int cnt, input string tag);
        int g;
        g = 0;
        collect();
        while (vq.size() < cnt && g < 5000) begin
            idle(1);
            #2;
            collect();
            g++;
        end
        chk({tag, "_wait"}, 32'(vq.size() >= cnt), 32'd1);
    endtask

    // Control flags, data pass-through and zero syndromes of one codeword.
    task automatic check_frame(input string tag, input int base, input int ndata, input int dbase);
        int acc;
        if (base + ndata + 30 > vq.size()) begin
            chk({tag, "_len"}, 32'(vq.size()), 32'(base + ndata + 30));
            return;
        end
        for (int k = 0; k < ndata + 30; k++) begin
            chk({tag, "_ctl"}, {29'd0, vq[base+k].sop, vq[base+k].eop, vq[base+k].flag},
                {29'd0, k == 0, k == ndata + 29, k >= ndata});
            if (k < ndata) chk({tag, "_dat"}, 32'(vq[base+k].dat), 32'(sent[dbase+k]));
        end
        for (int i = 0; i < 30; i++) begin
            acc = 0;
            for (int k = 0; k < ndata + 30; k++) acc = gmul(acc, exp_t[i]) ^ int'(vq[base+k].dat);
            chk({tag, "_syn"}, 32'(acc), 32'd0);
        end
    endtask

    initial begin : stim
        int x;
        int f;
        int gaps;
        ireset = 1'b1; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0; idat = 8'd0;

        // field tables for the reference model, alpha = x, poly 0x11D
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 285;
        end
        log_t[0] = 0;
        for (int j = 0; j <= 30; j++) gb[j] = 0;
        gb[0] = 1;
        for (int k = 0; k < 30; k++) begin
            for (int j = 30; j > 0; j--) gb[j] = gb[j-1] ^ gmul(gb[j], exp_t[k]);
            gb[0] = gmul(gb[0], exp_t[k]);
        end

        // reset state
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        chk("rst_oval", 32'(oval), 32'd0);
        chk("rst_odat", 32'(odat), 32'd0);
        chk("rst_flags", {29'd0, osop, oeop, oflag}, 32'd0);
        chk("rst_ordy", 32'(ordy), 32'd1);
        ireset = 1'b0;
        mon_en = 1'b1;

        // all-zero full-length frame
        clear_logs();
        for (int k = 0; k < 210; k++) put(k == 0, k == 209, 8'd0);
        wait_out(240, "zero");
        idle(3);
        collect();
        chk("zero_count", 32'(vq.size()), 32'd240);
        check_frame("zero", 0, 210, 0);
        for (int k = 210; k < 240 && k < vq.size(); k++) chk("zero_par", 32'(vq[k].dat), 32'd0);

        // 1-symbol frame: codeword equals the generator polynomial
        clear_logs();
        put(1'b1, 1'b1, 8'h01);
        wait_out(31, "one");
        idle(2);
        collect();
        chk("one_count", 32'(vq.size()), 32'd31);
        if (vq.size() == 31) begin
            chk("one_first", 32'(vq[0].dat), 32'd1);
            for (int j = 1; j <= 30; j++) chk("one_gen", 32'(vq[j].dat), 32'(gb[30-j]));
            chk("one_g0_alpha180", 32'(vq[30].dat), 32'(exp_t[180]));
        end
        check_frame("one", 0, 1, 0);

        // back-to-back random frames
        clear_logs();
        send_rand(210, 1'b1);
        frame_a = sent;
        rdy_low = 0;
        send_rand(210, 1'b1);
        chk("b2b_ordy_low", 32'(rdy_low), 32'd30);
        wait_out(480, "b2b");
        idle(2);
        collect();
        check_frame("b2b_a", 0, 210, 0);
        check_frame("b2b_b", 240, 210, 210);
        f = 0;
        while (f < mq.size() && !mq[f].val) f++;
        gaps = 0;
        for (int k = 0; k < 480; k++) if (f + k >= mq.size() || !mq[f+k].val) gaps++;
        chk("b2b_gaps", 32'(gaps), 32'd0);
        refa.delete();
        for (int k = 0; k < 240 && k < vq.size(); k++) refa.push_back(vq[k]);

        // same frame with a random clock enable
        clear_logs();
        rnd_ena = 1'b1;
        foreach (frame_a[k]) put(k == 0, k == 209, 8'(frame_a[k]));
        wait_out(240, "ena");
        rnd_ena = 1'b0;
        idle(2);
        collect();
        chk("ena_count", 32'(vq.size()), 32'd240);
        for (int k = 0; k < 240 && k < vq.size() && k < refa.size(); k++)
            chk("ena_rand", 32'(vq[k]), 32'(refa[k]));

        // reset in the middle of the parity phase
        clear_logs();
        send_rand(5, 1'b1);
        wait_out(15, "rstp");
        chk("rstp_at10", 32'(vq.size()), 32'd15);
        @(negedge iclk);
        ireset = 1'b1; iclkena = 1'b1; ival = 1'b0; isop = 1'b0; ieop = 1'b0;
        @(posedge iclk);
        #1;
        chk("rstp_oval", 32'(oval), 32'd0);
        chk("rstp_odat", 32'(odat), 32'd0);
        chk("rstp_flags", {29'd0, osop, oeop, oflag}, 32'd0);
        chk("rstp_ordy", 32'(ordy), 32'd1);
        @(negedge iclk);
        ireset = 1'b0;
        clear_logs();
        send_rand(20, 1'b1);
        wait_out(50, "post_rst");
        idle(2);
        collect();
        chk("post_rst_count", 32'(vq.size()), 32'd50);
        check_frame("post_rst", 0, 20, 0);

        // isop restart at symbol 100 and forced eop after 210 symbols
        clear_logs();
        for (int k = 0; k < 99; k++) put(k == 0, 1'b0, 8'($urandom_range(0, 255)));
        for (int k = 0; k < 210; k++) put(k == 0, 1'b0, 8'($urandom_range(0, 255)));
        #1;
        chk("restart_forced_ordy", 32'(ordy), 32'd0);
        wait_out(339, "restart");
        idle(2);
        collect();
        chk("restart_count", 32'(vq.size()), 32'd339);
        if (vq.size() >= 99) begin
            chk("restart_sop0", 32'(vq[0].sop), 32'd1);
            for (int k = 0; k < 99; k++)
                chk("restart_head", {23'd0, vq[k].flag, vq[k].dat}, {23'd0, 1'b0, 8'(sent[k])});
        end
        check_frame("restart", 99, 210, 99);

        // 215-symbol frame without ieop: parity after symbol 210
        clear_logs();
        rdy_low = 0;
        send_rand(215, 1'b0);
        chk("over_ordy_low", 32'(rdy_low), 32'd30);
        wait_out(245, "over");
        idle(2);
        collect();
        chk("over_count", 32'(vq.size()), 32'd245);
        check_frame("over", 0, 210, 0);
        for (int k = 240; k < 245 && k < vq.size(); k++)
            chk("over_tail", {23'd0, vq[k].flag, vq[k].dat}, {23'd0, 1'b0, 8'(sent[k-30])});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
